// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forward-select codes and the bundled per-stage enable/flush controls.
package cpu_hazard_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_en;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Everything frozen: no register loads, no bubbles.
    localparam pipe_ctrl_t CTRL_HOLD = '0;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en:        1'b1,
        if_id_en:     1'b1,
        if_id_flush:  1'b0,
        id_ex_en:     1'b1,
        id_ex_flush:  1'b0,
        ex_mem_en:    1'b1,
        ex_mem_flush: 1'b0,
        mem_wb_en:    1'b1,
        mem_wb_flush: 1'b0
    };

    // Bits needed to hold the initial wait count MEM_LAT-2 (at least one bit).
    function automatic int wcnt_width(input int mem_lat);
        return (mem_lat > 2) ? $clog2(mem_lat - 1) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle. The master side is the core
// datapath (supplies stage fields, consumes controls); the slave side is the controller.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  enable;
    logic [REG_ADDR_W-1:0] rs1_IF_ID;
    logic [REG_ADDR_W-1:0] rs2_IF_ID;
    logic [REG_ADDR_W-1:0] rs1_ID_EX;
    logic [REG_ADDR_W-1:0] rs2_ID_EX;
    logic [REG_ADDR_W-1:0] rd_ID_EX;
    logic                  mem_read_ID_EX;
    logic [REG_ADDR_W-1:0] rd_EX_MEM;
    logic                  reg_write_EX_MEM;
    logic                  mem_access_EX_MEM;
    logic                  redirect_EX_MEM;
    logic [REG_ADDR_W-1:0] rd_MEM_WB;
    logic                  reg_write_MEM_WB;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_flush;
    logic                  ex_mem_en;
    logic                  ex_mem_flush;
    logic                  mem_wb_en;
    logic                  mem_wb_flush;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output enable, rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX,
               mem_read_ID_EX, rd_EX_MEM, reg_write_EX_MEM, mem_access_EX_MEM,
               redirect_EX_MEM, rd_MEM_WB, reg_write_MEM_WB,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               ex_mem_flush, mem_wb_en, mem_wb_flush, forward_a, forward_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  enable, rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX,
               mem_read_ID_EX, rd_EX_MEM, reg_write_EX_MEM, mem_access_EX_MEM,
               redirect_EX_MEM, rd_MEM_WB, reg_write_MEM_WB,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               ex_mem_flush, mem_wb_en, mem_wb_flush, forward_a, forward_b,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Operand forward select for one execute-stage source register; the younger
// producer in EX_MEM takes priority over the one in MEM_WB, and x0 never forwards.
module fwd_sel
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_ex_mem_i,
    input  logic                  reg_write_ex_mem_i,
    input  logic [REG_ADDR_W-1:0] rd_mem_wb_i,
    input  logic                  reg_write_mem_wb_i,
    output logic [1:0]            fwd_o
);

    always_comb begin
        // NOTE: output takes a default before the if-chain so no path leaves it unassigned (no latch).
        fwd_o = FWD_RF;
        if (reg_write_ex_mem_i && (rd_ex_mem_i != '0) && (rd_ex_mem_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_mem_wb_i && (rd_mem_wb_i != '0) && (rd_mem_wb_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, redirect squash
// and fixed-latency data-memory stall. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_ctrl_unit
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    hazard_ctrl_if.slave hz
);

    localparam int                WCNT_W      = wcnt_width(MEM_LAT);
    localparam bit                MULTI_CYCLE = (MEM_LAT > 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT   = (MEM_LAT > 2) ? WCNT_W'(MEM_LAT - 2) : '0;

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_stall;
    logic              load_use;
    logic [1:0]        fwd_a, fwd_b;
    pipe_ctrl_t        ctrl;

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i               (hz.rs1_ID_EX),
        .rd_ex_mem_i        (hz.rd_EX_MEM),
        .reg_write_ex_mem_i (hz.reg_write_EX_MEM),
        .rd_mem_wb_i        (hz.rd_MEM_WB),
        .reg_write_mem_wb_i (hz.reg_write_MEM_WB),
        .fwd_o              (fwd_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i               (hz.rs2_ID_EX),
        .rd_ex_mem_i        (hz.rd_EX_MEM),
        .reg_write_ex_mem_i (hz.reg_write_EX_MEM),
        .rd_mem_wb_i        (hz.rd_MEM_WB),
        .reg_write_mem_wb_i (hz.reg_write_MEM_WB),
        .fwd_o              (fwd_b)
    );

    // An access costs MEM_LAT-1 stall cycles: one in IDLE, then MEM_LAT-2 counted down in WAIT.
    assign mem_stall = ((state_q == IDLE) && hz.mem_access_EX_MEM && MULTI_CYCLE) ||
                       ((state_q == WAIT) && (wcnt_q != '0));

    assign load_use = hz.mem_read_ID_EX && (hz.rd_ID_EX != '0) &&
                      ((hz.rd_ID_EX == hz.rs1_IF_ID) || (hz.rd_ID_EX == hz.rs2_IF_ID));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (hz.enable) begin
            unique case (state_q)
                IDLE: begin
                    if (hz.mem_access_EX_MEM && MULTI_CYCLE) begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
                WAIT: begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Priority: reset/enable=0 > memory stall > redirect > load-use.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!arst_n || !hz.enable) begin
            ctrl = CTRL_HOLD;
        end else if (mem_stall) begin
            ctrl              = CTRL_HOLD;
            ctrl.mem_wb_en    = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (hz.redirect_EX_MEM) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    assign hz.pc_en        = ctrl.pc_en;
    assign hz.if_id_en     = ctrl.if_id_en;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_en     = ctrl.id_ex_en;
    assign hz.id_ex_flush  = ctrl.id_ex_flush;
    assign hz.ex_mem_en    = ctrl.ex_mem_en;
    assign hz.ex_mem_flush = ctrl.ex_mem_flush;
    assign hz.mem_wb_en    = ctrl.mem_wb_en;
    assign hz.mem_wb_flush = ctrl.mem_wb_flush;
    assign hz.forward_a    = arst_n ? fwd_a : FWD_RF;
    assign hz.forward_b    = arst_n ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_event;
    logic             flush_event;

    // Only stalls and redirects actually applied this cycle are counted.
    assign stall_event = hz.enable && (mem_stall || (load_use && !hz.redirect_EX_MEM));
    assign flush_event = hz.enable && hz.redirect_EX_MEM && !mem_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_event && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (MEM_LAT = 1, 3, 4),
// control vectors ordered {pc,if_id_en,if_id_fl,id_ex_en,id_ex_fl,ex_mem_en,ex_mem_fl,mem_wb_en,mem_wb_fl}.
module tb_hazard_ctrl_unit;

    localparam logic [8:0] C_HOLD   = 9'b000000000;
    localparam logic [8:0] C_RUN    = 9'b110101010;
    localparam logic [8:0] C_MSTALL = 9'b000000011;
    localparam logic [8:0] C_REDIR  = 9'b111111110;
    localparam logic [8:0] C_LDUSE  = 9'b000111010;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic arst_n;
    int   total;
    int   bad;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) hif1 ();
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) hif3 ();
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4)) hif4 ();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .MEM_LAT(1), .CNT_W(4)) u_l1 (.clk(clk), .arst_n(arst_n), .hz(hif1));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .MEM_LAT(3), .CNT_W(4)) u_l3 (.clk(clk), .arst_n(arst_n), .hz(hif3));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .MEM_LAT(4), .CNT_W(4)) u_l4 (.clk(clk), .arst_n(arst_n), .hz(hif4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctl1();
        return {hif1.pc_en, hif1.if_id_en, hif1.if_id_flush, hif1.id_ex_en, hif1.id_ex_flush,
                hif1.ex_mem_en, hif1.ex_mem_flush, hif1.mem_wb_en, hif1.mem_wb_flush};
    endfunction

    function automatic logic [8:0] ctl3();
        return {hif3.pc_en, hif3.if_id_en, hif3.if_id_flush, hif3.id_ex_en, hif3.id_ex_flush,
                hif3.ex_mem_en, hif3.ex_mem_flush, hif3.mem_wb_en, hif3.mem_wb_flush};
    endfunction

    function automatic logic [8:0] ctl4();
        return {hif4.pc_en, hif4.if_id_en, hif4.if_id_flush, hif4.id_ex_en, hif4.id_ex_flush,
                hif4.ex_mem_en, hif4.ex_mem_flush, hif4.mem_wb_en, hif4.mem_wb_flush};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_all();
        hif1.enable = 1'b1; hif1.rs1_IF_ID = '0; hif1.rs2_IF_ID = '0; hif1.rs1_ID_EX = '0;
        hif1.rs2_ID_EX = '0; hif1.rd_ID_EX = '0; hif1.mem_read_ID_EX = 1'b0; hif1.rd_EX_MEM = '0;
        hif1.reg_write_EX_MEM = 1'b0; hif1.mem_access_EX_MEM = 1'b0; hif1.redirect_EX_MEM = 1'b0;
        hif1.rd_MEM_WB = '0; hif1.reg_write_MEM_WB = 1'b0;
        hif3.enable = 1'b1; hif3.rs1_IF_ID = '0; hif3.rs2_IF_ID = '0; hif3.rs1_ID_EX = '0;
        hif3.rs2_ID_EX = '0; hif3.rd_ID_EX = '0; hif3.mem_read_ID_EX = 1'b0; hif3.rd_EX_MEM = '0;
        hif3.reg_write_EX_MEM = 1'b0; hif3.mem_access_EX_MEM = 1'b0; hif3.redirect_EX_MEM = 1'b0;
        hif3.rd_MEM_WB = '0; hif3.reg_write_MEM_WB = 1'b0;
        hif4.enable = 1'b1; hif4.rs1_IF_ID = '0; hif4.rs2_IF_ID = '0; hif4.rs1_ID_EX = '0;
        hif4.rs2_ID_EX = '0; hif4.rd_ID_EX = '0; hif4.mem_read_ID_EX = 1'b0; hif4.rd_EX_MEM = '0;
        hif4.reg_write_EX_MEM = 1'b0; hif4.mem_access_EX_MEM = 1'b0; hif4.redirect_EX_MEM = 1'b0;
        hif4.rd_MEM_WB = '0; hif4.reg_write_MEM_WB = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        arst_n = 1'b0;
        clear_all();

        // Reset: forwarding and memory-access conditions present, outputs still inactive.
        hif1.rd_EX_MEM = 5'd5; hif1.reg_write_EX_MEM = 1'b1; hif1.rs1_ID_EX = 5'd5;
        hif4.mem_access_EX_MEM = 1'b1;
        sample();
        check("rst_ctl1", 32'(ctl1()), 32'(C_HOLD));
        check("rst_fwd_a", 32'(hif1.forward_a), 32'd0);
        check("rst_ctl4", 32'(ctl4()), 32'(C_HOLD));
        check("rst_scnt", 32'(hif4.stall_cnt), 32'd0);
        tick();
        clear_all();
        arst_n = 1'b1;

        // Forwarding priority and x0 exclusion.
        hif1.rd_EX_MEM = 5'd5; hif1.reg_write_EX_MEM = 1'b1;
        hif1.rd_MEM_WB = 5'd5; hif1.reg_write_MEM_WB = 1'b1;
        hif1.rs1_ID_EX = 5'd5; hif1.rs2_ID_EX = 5'd9;
        sample();
        check("fwd_a_mem", 32'(hif1.forward_a), 32'd2);
        check("fwd_b_none", 32'(hif1.forward_b), 32'd0);
        check("ctl_default", 32'(ctl1()), 32'(C_RUN));
        tick();
        hif1.rd_EX_MEM = 5'd0;
        sample();
        check("fwd_a_wb", 32'(hif1.forward_a), 32'd1);
        tick();
        hif1.rd_MEM_WB = 5'd0; hif1.rs1_ID_EX = 5'd0;
        sample();
        check("fwd_a_x0", 32'(hif1.forward_a), 32'd0);
        tick();
        hif1.rs2_ID_EX = 5'd3; hif1.rd_MEM_WB = 5'd3; hif1.rd_EX_MEM = 5'd3; hif1.reg_write_EX_MEM = 1'b0;
        sample();
        check("fwd_b_wb", 32'(hif1.forward_b), 32'd1);
        tick();
        hif1.reg_write_EX_MEM = 1'b1;
        sample();
        check("fwd_b_mem", 32'(hif1.forward_b), 32'd2);
        tick();
        clear_all();

        // Load-use: one stall cycle, then the bubble clears the hazard.
        hif1.mem_read_ID_EX = 1'b1; hif1.rd_ID_EX = 5'd7; hif1.rs2_IF_ID = 5'd7;
        sample();
        check("lduse", 32'(ctl1()), 32'(C_LDUSE));
        tick();
        hif1.mem_read_ID_EX = 1'b0;
        sample();
        check("lduse_after", 32'(ctl1()), 32'(C_RUN));
        tick();
        hif1.mem_read_ID_EX = 1'b1; hif1.rd_ID_EX = 5'd0; hif1.rs1_IF_ID = 5'd0; hif1.rs2_IF_ID = 5'd0;
        sample();
        check("lduse_x0", 32'(ctl1()), 32'(C_RUN));
        tick();

        // Redirect concurrent with load-use: squash wins.
        hif1.rd_ID_EX = 5'd7; hif1.rs1_IF_ID = 5'd7; hif1.redirect_EX_MEM = 1'b1;
        sample();
        check("redir_lduse", 32'(ctl1()), 32'(C_REDIR));
        tick();
        hif1.enable = 1'b0;
        sample();
        check("enable_off", 32'(ctl1()), 32'(C_HOLD));
        tick();
        clear_all();

        // MEM_LAT=1: accesses never stall.
        hif1.mem_access_EX_MEM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check($sformatf("lat1_acc%0d", i), 32'(ctl1()), 32'(C_RUN));
            tick();
        end
        clear_all();

        // MEM_LAT=4: three stall cycles, then one advance cycle.
        hif4.mem_access_EX_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("lat4_stall%0d", i), 32'(ctl4()), 32'(C_MSTALL));
            tick();
        end
        sample();
        check("lat4_release", 32'(ctl4()), 32'(C_RUN));
        tick();
        hif4.mem_access_EX_MEM = 1'b0;
        sample();
        check("lat4_idle", 32'(ctl4()), 32'(C_RUN));
        tick();

        // MEM_LAT=3: redirect frozen behind the stall, applied on release.
        hif3.mem_access_EX_MEM = 1'b1; hif3.redirect_EX_MEM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check($sformatf("lat3_redir_stall%0d", i), 32'(ctl3()), 32'(C_MSTALL));
            tick();
        end
        sample();
        check("lat3_redir_release", 32'(ctl3()), 32'(C_REDIR));
        tick();
        hif3.mem_access_EX_MEM = 1'b0; hif3.redirect_EX_MEM = 1'b0;
        sample();
        check("lat3_after", 32'(ctl3()), 32'(C_RUN));
        tick();

        // Reset in WAIT: outputs inactive at once, stall dropped afterwards.
        hif3.mem_access_EX_MEM = 1'b1;
        hif3.rd_EX_MEM = 5'd4; hif3.reg_write_EX_MEM = 1'b1; hif3.rs2_ID_EX = 5'd4;
        tick();
        hif3.mem_access_EX_MEM = 1'b0;
        sample();
        check("lat3_wait", 32'(ctl3()), 32'(C_MSTALL));
        #1;
        arst_n = 1'b0;
        #1;
        check("rst_wait_ctl", 32'(ctl3()), 32'(C_HOLD));
        check("rst_wait_fwd", 32'(hif3.forward_b), 32'd0);
        tick();
        arst_n = 1'b1;
        sample();
        check("rst_wait_idle", 32'(ctl3()), 32'(C_RUN));
        check("rst_wait_fwd2", 32'(hif3.forward_b), 32'd2);
        tick();
        clear_all();

        // Counters: 20 load-use stall cycles saturate a 4-bit counter; one redirect.
        hif4.mem_read_ID_EX = 1'b1; hif4.rd_ID_EX = 5'd2; hif4.rs1_IF_ID = 5'd2;
        for (int i = 0; i < 10; i++) tick();
        check("scnt_10", 32'(hif4.stall_cnt), PERF ? 32'd10 : 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("scnt_sat", 32'(hif4.stall_cnt), PERF ? 32'd15 : 32'd0);
        clear_all();
        hif4.redirect_EX_MEM = 1'b1;
        tick();
        clear_all();
        sample();
        check("fcnt_1", 32'(hif4.flush_cnt), PERF ? 32'd1 : 32'd0);
        check("scnt_hold", 32'(hif4.stall_cnt), PERF ? 32'd15 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
